if_fetch_stage: RTL

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, selects the next PC from sequential, branch, jump, jump-register, exception, interrupt and return redirects, reads the instruction ROM, and feeds the IF/ID register with PC+4 and the fetched instruction. It also latches the exception PC and drives the IF/ID flush on every taken redirect.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/inst_rom.sv | 20 ++
 rtl/if_fetch_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline package.
// Holds the reset PC and handler vector defaults, the machine word width and
// the instruction ROM depth default. The ID-stage exception logic uses these
// same vectors. It also defines the next-PC source encoding used by the fetch
// stage, the PC+4 helper and the built-in instruction ROM image.
package pipe_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] RESET_PC_DEF   = 32'h8000_0000;
   localparam logic [WORD_W-1:0] IRQ_VECTOR_DEF = 32'h8000_0004;
   localparam logic [WORD_W-1:0] EXC_VECTOR_DEF = 32'h8000_0008;
   localparam int                IMEM_WORDS_DEF = 256;

   typedef logic [WORD_W-1:0] word_t;

   // Next-PC source, one value per row of the redirect priority list.
   // The last two values are the only ones that do not flush IF/ID.
   typedef enum logic [2:0] {
      SEL_EXC,
      SEL_IRQ,
      SEL_ERET,
      SEL_JR,
      SEL_JUMP,
      SEL_BRANCH,
      SEL_HOLD,
      SEL_SEQ
   } pc_sel_e;

   // PC+4 keeps bit 31 (kernel) untouched.
   // Bits 30:0 wrap to zero at the top of the address space.
   function automatic word_t pc_plus4(input word_t pc);
      return {pc[31], pc[30:0] + 31'd4};
   endfunction

   // Contents of the instruction ROM, indexed by word address.
   // The upper bytes are folded in so that every address bit takes part.
   // For any index that fits in one byte this yields
   // {idx, ~idx, 8'h3C, idx ^ 8'h5A}.
   function automatic word_t rom_image(input word_t idx);
      logic [7:0] b;
      b = idx[7:0] ^ idx[15:8] ^ idx[23:16] ^ idx[31:24];
      return {b, ~b, 8'h3C, b ^ 8'h5A};
   endfunction

endpackage

// File: rtl/inst_rom.sv
// Instruction ROM.
// This is a purely combinational read of the built-in image held in pipe_pkg.
//   addr : word address, $clog2(IMEM_WORDS) bits
//   data : instruction word at that address
module inst_rom
   import pipe_pkg::*;
#(
   parameter int IMEM_WORDS = IMEM_WORDS_DEF,
   parameter int AW         = $clog2(IMEM_WORDS)
) (
   input  logic [AW-1:0]     addr,
   output logic [WORD_W-1:0] data
);

   // The address is zero-extended to a full word before the image lookup.
   always_comb begin
      data = rom_image(word_t'(addr));
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage.
// It owns the PC and the exception PC (EPC). Each cycle it picks the next PC
// from the sequential, branch, jump, jump-register, exception, interrupt and
// eret sources. It reads the instruction ROM with zero latency and flushes
// IF/ID whenever a redirect is taken.
//   clk, reset                 : clock, asynchronous active-high reset
//   CStall                     : hold the PC
//   CBranch/IBranchTarget      : taken branch from ID
//   CJump/IJumpTarget          : j/jal from ID
//   CJr/IJrTarget              : jr/jalr from ID
//   CExc/IExcPC                : ID-stage exception and faulting PC
//   IIrq                       : asynchronous level interrupt
//   CEret                      : return from exception
//   OPC, OPCAdd4, OInst        : current PC, PC+4 and fetched word to IF/ID
//   OFlush                     : IF/ID flush, combinational
//   OEPC                       : exception PC register
//   OKernel                    : PC[31]
module if_fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [WORD_W-1:0] IRQ_VECTOR = IRQ_VECTOR_DEF,
   parameter logic [WORD_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF,
   parameter int                IMEM_WORDS = IMEM_WORDS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              CStall,
   input  logic              CBranch,
   input  logic [WORD_W-1:0] IBranchTarget,
   input  logic              CJump,
   input  logic [WORD_W-1:0] IJumpTarget,
   input  logic              CJr,
   input  logic [WORD_W-1:0] IJrTarget,
   input  logic              CExc,
   input  logic [WORD_W-1:0] IExcPC,
   input  logic              IIrq,
   input  logic              CEret,
   output logic [WORD_W-1:0] OPC,
   output logic [WORD_W-1:0] OPCAdd4,
   output logic [WORD_W-1:0] OInst,
   output logic              OFlush,
   output logic [WORD_W-1:0] OEPC,
   output logic              OKernel
);

   localparam int AW = $clog2(IMEM_WORDS);

   logic [WORD_W-1:0] pc;
   logic [WORD_W-1:0] epc;
   logic [WORD_W-1:0] pc_next;
   logic [WORD_W-1:0] epc_next;
   logic              irq_meta;
   logic              irq_s;
   logic              irq_take;
   pc_sel_e           sel;
   logic [AW-1:0]     rom_addr;
   logic [WORD_W-1:0] rom_data;
   logic              out_of_range;

   // Two-flop synchronizer for the asynchronous interrupt level.
   // Only irq_s is used by the redirect logic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_meta <= 1'b0;
         irq_s    <= 1'b0;
      end else begin
         irq_meta <= IIrq;
         irq_s    <= irq_meta;
      end
   end

   // Interrupts are masked in kernel space. They are also held off while
   // stalled. The level stays high, so a held-off interrupt is taken later
   // rather than lost.
   assign irq_take = irq_s && !pc[31] && !CStall;

   // Next-PC source selection in priority order.
   // Exception and eret are honoured even during a stall. The ID-stage
   // redirects are only honoured when the pipe is moving.
   always_comb begin
      sel = SEL_SEQ;
      if (CExc) begin
         sel = SEL_EXC;
      end else if (irq_take) begin
         sel = SEL_IRQ;
      end else if (CEret) begin
         sel = SEL_ERET;
      end else if (!CStall && CJr) begin
         sel = SEL_JR;
      end else if (!CStall && CJump) begin
         sel = SEL_JUMP;
      end else if (!CStall && CBranch) begin
         sel = SEL_BRANCH;
      end else if (CStall) begin
         sel = SEL_HOLD;
      end
   end

   // Next PC, next EPC and the flush request for the selected source.
   // Targets are passed through unaligned. Alignment checks belong to the
   // decoder.
   always_comb begin
      pc_next  = OPCAdd4;
      epc_next = epc;
      OFlush   = 1'b0;
      case (sel)
         SEL_EXC: begin
            pc_next  = EXC_VECTOR;
            epc_next = IExcPC;
            OFlush   = 1'b1;
         end
         SEL_IRQ: begin
            pc_next  = IRQ_VECTOR;
            epc_next = pc;
            OFlush   = 1'b1;
         end
         SEL_ERET: begin
            pc_next = epc;
            OFlush  = 1'b1;
         end
         SEL_JR: begin
            pc_next = IJrTarget;
            OFlush  = 1'b1;
         end
         SEL_JUMP: begin
            pc_next = IJumpTarget;
            OFlush  = 1'b1;
         end
         SEL_BRANCH: begin
            pc_next = IBranchTarget;
            OFlush  = 1'b1;
         end
         SEL_HOLD: begin
            pc_next = pc;
         end
         default: begin
            pc_next = OPCAdd4;
         end
      endcase
   end

   // PC and EPC registers.
   // Reset wins over any redirect that was pending in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc  <= RESET_PC;
         epc <= '0;
      end else begin
         pc  <= pc_next;
         epc <= epc_next;
      end
   end

   // The ROM index ignores the kernel bit. Any set bit between the top of
   // the ROM and bit 30 means the fetch is outside the ROM, and a nop
   // (all zeros) is returned instead.
   assign rom_addr     = pc[AW+1:2];
   assign out_of_range = |pc[30:AW+2];

   inst_rom #(
      .IMEM_WORDS (IMEM_WORDS),
      .AW         (AW)
   ) u_inst_rom (
      .addr (rom_addr),
      .data (rom_data)
   );

   // Fetch outputs, all combinational from the current PC.
   always_comb begin
      OPC     = pc;
      OPCAdd4 = pc_plus4(pc);
      OInst   = out_of_range ? '0 : rom_data;
      OEPC    = epc;
      OKernel = pc[31];
   end

endmodule
